// File: rtl/nes_cart_pkg.sv
// Shared types and constants for the NES cartridge block and its iNES loader.
package nes_cart_pkg;

  // state    | meaning
  // IDLE     | no load since reset
  // HDR      | collecting the 16 header bytes
  // TRAIN    | discarding the 512-byte trainer
  // PRG      | writing PRG-ROM bytes
  // CHR      | writing CHR-ROM bytes
  // DONE/ERR | load finished / aborted, bus released
  typedef enum logic [2:0] {
    ST_IDLE, ST_HDR, ST_TRAIN, ST_PRG, ST_CHR, ST_DONE, ST_ERR
  } state_t;

  localparam logic [31:0] INES_MAGIC = 32'h4E45_531A;

  localparam int HDR_LEN     = 16;
  localparam int PRG_UNIT    = 16384;
  localparam int CHR_UNIT    = 8192;
  localparam int TRAINER_LEN = 512;

  localparam int CFG_W           = 40;
  localparam int CFG_MAPPER_LSB  = 0;
  localparam int CFG_MIRROR_V    = 16;
  localparam int CFG_BATTERY     = 17;
  localparam int CFG_FOUR_SCREEN = 18;
  localparam int CFG_CHR_RAM     = 32;
  localparam int CFG_PRG32K      = 33;

endpackage

// File: rtl/ines_hdr_check.sv
// Combinational iNES header validation and cartridge config word build.
module ines_hdr_check
  import nes_cart_pkg::*;
#(
  parameter int MAX_PRG_UNITS = 2,
  parameter int MAX_CHR_UNITS = 1
) (
  input  logic [31:0]      magic,
  input  logic [7:0]       prg_units,
  input  logic [7:0]       chr_units,
  input  logic [7:0]       flags6,
  input  logic [3:0]       flags7_hi,
  output logic             ok,
  output logic             trainer,
  output logic [CFG_W-1:0] cfg
);

  logic [7:0] mapper;

  always_comb begin
    mapper  = {flags7_hi, flags6[7:4]};
    ok      = (magic == INES_MAGIC) && (mapper == 8'd0) &&
              (prg_units != 8'd0) && (prg_units <= 8'(MAX_PRG_UNITS)) &&
              (chr_units <= 8'(MAX_CHR_UNITS));
    trainer = flags6[2];

    cfg                          = '0;
    cfg[CFG_MAPPER_LSB +: 8]     = mapper;
    cfg[CFG_MIRROR_V]            = flags6[0];
    cfg[CFG_BATTERY]             = flags6[1];
    cfg[CFG_FOUR_SCREEN]         = flags6[3];
    cfg[CFG_CHR_RAM]             = (chr_units == 8'd0);
    cfg[CFG_PRG32K]              = (prg_units == 8'd2);
  end

endmodule

// File: rtl/ines_loader.sv
// Parses an iNES byte stream, publishes the cartridge config word and
// writes PRG/CHR payload into the cartridge memories.
module ines_loader
  import nes_cart_pkg::*;
#(
  parameter int MAX_PRG_UNITS = 2,
  parameter int MAX_CHR_UNITS = 1
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic [7:0]       rx_data_in,
  input  logic             rx_valid_in,
  output logic             rx_ready_out,
  output logic [CFG_W-1:0] cfg_out,
  output logic             cfg_upd_out,
  output logic             prg_nce_out,
  output logic             prg_r_nw_out,
  output logic [14:0]      prg_a_out,
  output logic [7:0]       prg_d_out,
  output logic [13:0]      chr_a_out,
  output logic             chr_r_nw_out,
  output logic [7:0]       chr_d_out,
  output logic             busy_out,
  output logic             done_out,
  output logic             error_out
);

  state_t           state, state_nxt;
  logic [15:0]      cnt;
  logic [15:0]      len_m1;
  logic [7:0]       hdr_q [8];
  logic             xfer, last;
  logic             hdr_ok, hdr_trainer;
  logic [CFG_W-1:0] hdr_cfg;

  ines_hdr_check #(
    .MAX_PRG_UNITS(MAX_PRG_UNITS),
    .MAX_CHR_UNITS(MAX_CHR_UNITS)
  ) u_hdr_check (
    .magic    ({hdr_q[0], hdr_q[1], hdr_q[2], hdr_q[3]}),
    .prg_units(hdr_q[4]),
    .chr_units(hdr_q[5]),
    .flags6   (hdr_q[6]),
    .flags7_hi(hdr_q[7][7:4]),
    .ok       (hdr_ok),
    .trainer  (hdr_trainer),
    .cfg      (hdr_cfg)
  );

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    rx_ready_out = (state == ST_HDR) || (state == ST_TRAIN) ||
                   (state == ST_PRG) || (state == ST_CHR);
    busy_out     = rx_ready_out;
    done_out     = (state == ST_DONE);
    error_out    = (state == ST_ERR);
    xfer         = rx_valid_in && rx_ready_out && !start_in;

    case (state)
      ST_HDR:   len_m1 = 16'(HDR_LEN - 1);
      ST_TRAIN: len_m1 = 16'(TRAINER_LEN - 1);
      ST_PRG:   len_m1 = 16'(int'(hdr_q[4]) * PRG_UNIT - 1);
      ST_CHR:   len_m1 = 16'(CHR_UNIT - 1);
      default:  len_m1 = 16'hFFFF;
    endcase
    last = (cnt == len_m1);

    state_nxt = state;
    if (start_in) begin
      state_nxt = ST_HDR;
    end else if (xfer && last) begin
      case (state)
        ST_HDR:   state_nxt = !hdr_ok ? ST_ERR : (hdr_trainer ? ST_TRAIN : ST_PRG);
        ST_TRAIN: state_nxt = ST_PRG;
        ST_PRG:   state_nxt = (hdr_q[5] != 8'd0) ? ST_CHR : ST_DONE;
        ST_CHR:   state_nxt = ST_DONE;
        default:  state_nxt = state;
      endcase
    end
  end

  // Write strobes are single-cycle and follow the accepted byte by one cycle.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      cnt          <= '0;
      cfg_out      <= '0;
      cfg_upd_out  <= 1'b0;
      prg_nce_out  <= 1'b1;
      prg_r_nw_out <= 1'b1;
      prg_a_out    <= '0;
      prg_d_out    <= '0;
      chr_r_nw_out <= 1'b1;
      chr_a_out    <= '0;
      chr_d_out    <= '0;
      for (int i = 0; i < 8; i++) hdr_q[i] <= '0;
    end else begin
      cfg_upd_out  <= 1'b0;
      prg_nce_out  <= 1'b1;
      prg_r_nw_out <= 1'b1;
      chr_r_nw_out <= 1'b1;
      if (start_in) begin
        cnt <= '0;
      end else if (xfer) begin
        cnt <= last ? '0 : cnt + 16'd1;
        case (state)
          ST_HDR: begin
            if (cnt < 16'd8) hdr_q[cnt[2:0]] <= rx_data_in;
            if (last && hdr_ok) begin
              cfg_out     <= hdr_cfg;
              cfg_upd_out <= 1'b1;
            end
          end
          ST_PRG: begin
            prg_nce_out  <= 1'b0;
            prg_r_nw_out <= 1'b0;
            prg_a_out    <= cnt[14:0];
            prg_d_out    <= rx_data_in;
          end
          ST_CHR: begin
            chr_r_nw_out <= 1'b0;
            chr_a_out    <= {1'b0, cnt[12:0]};
            chr_d_out    <= rx_data_in;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ines_loader.sv
// Self-checking bench for ines_loader: header vector table, random headers
// against a rule model, and full/partial loads checked by a write scoreboard.
module tb_ines_loader;

  localparam logic [31:0] GOOD = 32'h4E45_531A;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_ready, cfg_upd, prg_nce, prg_r_nw, chr_r_nw, busy, done, error;
  logic [39:0] cfg;
  logic [14:0] prg_a;
  logic [7:0]  prg_d, chr_d;
  logic [13:0] chr_a;

  ines_loader dut (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start),
    .rx_data_in(rx_data), .rx_valid_in(rx_valid), .rx_ready_out(rx_ready),
    .cfg_out(cfg), .cfg_upd_out(cfg_upd),
    .prg_nce_out(prg_nce), .prg_r_nw_out(prg_r_nw), .prg_a_out(prg_a), .prg_d_out(prg_d),
    .chr_a_out(chr_a), .chr_r_nw_out(chr_r_nw), .chr_d_out(chr_d),
    .busy_out(busy), .done_out(done), .error_out(error)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int upd_cnt = 0, prg_wr_cnt = 0, chr_wr_cnt = 0, prg_bad = 0, chr_bad = 0;
  int prg_base = 0, chr_base = 0, not_ready = 0;
  logic [14:0] prg_last_a = '0;
  logic [13:0] chr_last_a = '0;
  logic [7:0]  prg_img [32768];
  logic [7:0]  chr_img [8192];
  bit          gaps = 0;
  logic [39:0] last_cfg = '0;

  typedef struct {
    logic [31:0] magic;
    logic [7:0]  h4, h5, h6, h7;
    logic        exp_err;
    logic [39:0] exp_cfg;
  } hvec_t;
  hvec_t tbl [9];

  // Scoreboard: every write must land at the next sequential address with the file byte.
  always @(negedge clk) begin
    if (cfg_upd === 1'b1) upd_cnt++;
    if (rst_n && prg_nce !== prg_r_nw) prg_bad++;
    if (prg_nce === 1'b0 && prg_r_nw === 1'b0) begin
      if (prg_a != 15'(prg_wr_cnt - prg_base) || prg_d != prg_img[prg_a]) prg_bad++;
      prg_last_a = prg_a;
      prg_wr_cnt++;
    end
    if (chr_r_nw === 1'b0) begin
      if (chr_a != 14'(chr_wr_cnt - chr_base) || chr_d != chr_img[chr_a[12:0]]) chr_bad++;
      chr_last_a = chr_a;
      chr_wr_cnt++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Rule model of header acceptance and the config word: {ok, cfg}.
  function automatic logic [40:0] model_hdr(input logic [31:0] magic,
                                            input logic [7:0] h4, h5, h6, h7);
    int mapper;
    logic ok;
    logic [39:0] c;
    mapper = int'(h7[7:4]) * 16 + int'(h6[7:4]);
    ok = (magic == GOOD) && (mapper == 0) && (h4 >= 1) && (h4 <= 2) && (h5 <= 1);
    c = '0;
    c[7:0] = 8'(mapper);
    c[16]  = h6[0];
    c[17]  = h6[1];
    c[18]  = h6[3];
    c[32]  = (h5 == 0);
    c[33]  = (h4 == 2);
    return {ok, c};
  endfunction

  task automatic send_byte(input logic [7:0] b);
    if (gaps)
      for (int g = 0; g < 4 && $urandom_range(3) == 0; g++) begin
        rx_valid = 1'b0;
        tick();
      end
    rx_data  = b;
    rx_valid = 1'b1;
    if (rx_ready !== 1'b1) not_ready++;
    tick();
  endtask

  task automatic pulse_start();
    start    = 1'b1;
    rx_valid = 1'b0;
    tick();
    start    = 1'b0;
  endtask

  task automatic send_header(input logic [31:0] magic, input logic [7:0] h4, h5, h6, h7);
    logic [7:0] b [16];
    b[0] = magic[31:24]; b[1] = magic[23:16]; b[2] = magic[15:8]; b[3] = magic[7:0];
    b[4] = h4; b[5] = h5; b[6] = h6; b[7] = h7;
    for (int i = 8; i < 16; i++) b[i] = 8'($urandom);
    for (int i = 0; i < 16; i++) send_byte(b[i]);
  endtask

  task automatic hdr_case(input string tag, input logic [31:0] magic,
                          input logic [7:0] h4, h5, h6, h7,
                          input logic exp_err, input logic [39:0] exp_cfg);
    int u0;
    pulse_start();
    u0 = upd_cnt;
    send_header(magic, h4, h5, h6, h7);
    rx_valid = 1'b0;
    check({tag, " upd_pulse"}, cfg_upd, !exp_err);
    tick();
    check({tag, " upd_count"}, upd_cnt - u0, exp_err ? 0 : 1);
    check({tag, " error"}, error, exp_err);
    check({tag, " ready"}, rx_ready, !exp_err);
    check({tag, " busy"}, busy, !exp_err);
    check({tag, " cfg"}, cfg, exp_cfg);
  endtask

  task automatic check_reset(input string tag);
    check({tag, " cfg"}, cfg, 0);
    check({tag, " cfg_upd"}, cfg_upd, 0);
    check({tag, " prg_nce"}, prg_nce, 1);
    check({tag, " prg_r_nw"}, prg_r_nw, 1);
    check({tag, " chr_r_nw"}, chr_r_nw, 1);
    check({tag, " prg_a"}, prg_a, 0);
    check({tag, " prg_d"}, prg_d, 0);
    check({tag, " chr_a"}, chr_a, 0);
    check({tag, " chr_d"}, chr_d, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " error"}, error, 0);
    check({tag, " ready"}, rx_ready, 0);
  endtask

  initial begin
    int u0, pb, cb, pbad, cbad, nr;
    logic [40:0] m;
    logic [31:0] mg;
    logic [7:0]  h4, h5, h6, h7;

    tbl[0] = '{GOOD,          8'd1, 8'd0, 8'h0B, 8'h00, 1'b0, 40'h01_0007_0000};
    tbl[1] = '{32'h4E45_531B, 8'd1, 8'd1, 8'h00, 8'h00, 1'b1, 40'h01_0007_0000};
    tbl[2] = '{GOOD,          8'd1, 8'd1, 8'h10, 8'h00, 1'b1, 40'h01_0007_0000};
    tbl[3] = '{GOOD,          8'd3, 8'd1, 8'h00, 8'h00, 1'b1, 40'h01_0007_0000};
    tbl[4] = '{GOOD,          8'd0, 8'd1, 8'h00, 8'h00, 1'b1, 40'h01_0007_0000};
    tbl[5] = '{GOOD,          8'd1, 8'd2, 8'h00, 8'h00, 1'b1, 40'h01_0007_0000};
    tbl[6] = '{GOOD,          8'd1, 8'd1, 8'h00, 8'h10, 1'b1, 40'h01_0007_0000};
    tbl[7] = '{GOOD,          8'd2, 8'd1, 8'h01, 8'h00, 1'b0, 40'h02_0001_0000};
    tbl[8] = '{32'h4E45_531B, 8'd2, 8'd1, 8'h01, 8'h00, 1'b1, 40'h02_0001_0000};

    rst_n = 1'b0;
    tick();
    tick();
    check_reset("por");
    rst_n = 1'b1;
    tick();
    check("idle ready", rx_ready, 0);

    foreach (tbl[i]) begin
      hdr_case($sformatf("tbl%0d", i), tbl[i].magic, tbl[i].h4, tbl[i].h5,
               tbl[i].h6, tbl[i].h7, tbl[i].exp_err, tbl[i].exp_cfg);
      last_cfg = tbl[i].exp_cfg;
    end

    for (int i = 0; i < 16; i++) begin
      mg = ($urandom_range(4) == 0) ? (GOOD ^ (32'd1 << $urandom_range(31))) : GOOD;
      h4 = 8'($urandom_range(3));
      h5 = 8'($urandom_range(2));
      h6 = {($urandom_range(4) == 0) ? 4'($urandom_range(15)) : 4'd0, 4'($urandom)};
      h7 = {($urandom_range(5) == 0) ? 4'($urandom_range(15)) : 4'd0, 4'($urandom)};
      m  = model_hdr(mg, h4, h5, h6, h7);
      hdr_case($sformatf("rnd%0d", i), mg, h4, h5, h6, h7, !m[40],
               m[40] ? m[39:0] : last_cfg);
      if (m[40]) last_cfg = m[39:0];
    end

    // NROM-256, vertical mirroring, back-to-back bytes
    for (int i = 0; i < 32768; i++) prg_img[i] = 8'($urandom);
    for (int i = 0; i < 8192; i++)  chr_img[i] = 8'($urandom);
    pulse_start();
    u0 = upd_cnt; pb = prg_wr_cnt; cb = chr_wr_cnt; pbad = prg_bad; cbad = chr_bad; nr = not_ready;
    prg_base = prg_wr_cnt; chr_base = chr_wr_cnt;
    send_header(GOOD, 8'd2, 8'd1, 8'h01, 8'h00);
    for (int i = 0; i < 32768; i++) send_byte(prg_img[i]);
    for (int i = 0; i < 8192; i++)  send_byte(chr_img[i]);
    rx_valid = 1'b0;
    tick();
    check("n256 upd_count", upd_cnt - u0, 1);
    check("n256 cfg", cfg, 40'h02_0001_0000);
    check("n256 prg_writes", prg_wr_cnt - pb, 32768);
    check("n256 prg_last_a", prg_last_a, 15'h7FFF);
    check("n256 prg_bad", prg_bad - pbad, 0);
    check("n256 chr_writes", chr_wr_cnt - cb, 8192);
    check("n256 chr_last_a", chr_last_a, 14'h1FFF);
    check("n256 chr_bad", chr_bad - cbad, 0);
    check("n256 done", done, 1);
    check("n256 busy", busy, 0);
    check("n256 error", error, 0);
    check("n256 ready", rx_ready, 0);
    check("n256 stalls", not_ready - nr, 0);

    // NROM-128 with trainer, random valid gaps
    gaps = 1;
    for (int i = 0; i < 16384; i++) prg_img[i] = 8'($urandom);
    pulse_start();
    u0 = upd_cnt; pb = prg_wr_cnt; cb = chr_wr_cnt; pbad = prg_bad; nr = not_ready;
    prg_base = prg_wr_cnt; chr_base = chr_wr_cnt;
    send_header(GOOD, 8'd1, 8'd0, 8'h04, 8'h00);
    for (int i = 0; i < 512; i++) send_byte(8'($urandom));
    rx_valid = 1'b0;
    tick();
    check("trn no_writes", prg_wr_cnt - pb, 0);
    for (int i = 0; i < 16384; i++) send_byte(prg_img[i]);
    rx_valid = 1'b0;
    tick();
    gaps = 0;
    check("trn upd_count", upd_cnt - u0, 1);
    check("trn cfg", cfg, 40'h01_0000_0000);
    check("trn prg_writes", prg_wr_cnt - pb, 16384);
    check("trn prg_last_a", prg_last_a, 15'h3FFF);
    check("trn prg_bad", prg_bad - pbad, 0);
    check("trn chr_writes", chr_wr_cnt - cb, 0);
    check("trn done", done, 1);
    check("trn stalls", not_ready - nr, 0);

    // restart at PRG byte 100, with a byte offered alongside start
    pulse_start();
    pb = prg_wr_cnt; prg_base = prg_wr_cnt;
    send_header(GOOD, 8'd1, 8'd1, 8'h01, 8'h00);
    for (int i = 0; i < 100; i++) send_byte(prg_img[i]);
    start    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    tick();
    start    = 1'b0;
    rx_valid = 1'b0;
    check("rst_prg busy", busy, 1);
    check("rst_prg ready", rx_ready, 1);
    check("rst_prg done", done, 0);
    check("rst_prg cfg_held", cfg, 40'h00_0001_0000);
    tick();
    check("rst_prg writes", prg_wr_cnt - pb, 100);

    for (int i = 0; i < 16384; i++) prg_img[i] = 8'($urandom);
    u0 = upd_cnt; pb = prg_wr_cnt; cb = chr_wr_cnt; pbad = prg_bad; cbad = chr_bad; nr = not_ready;
    prg_base = prg_wr_cnt; chr_base = chr_wr_cnt;
    send_header(GOOD, 8'd1, 8'd1, 8'h03, 8'h00);
    for (int i = 0; i < 16384; i++) send_byte(prg_img[i]);
    for (int i = 0; i < 1000; i++)  send_byte(chr_img[i]);
    rx_valid = 1'b0;
    tick();
    check("reload upd_count", upd_cnt - u0, 1);
    check("reload cfg", cfg, 40'h00_0003_0000);
    check("reload prg_writes", prg_wr_cnt - pb, 16384);
    check("reload prg_last_a", prg_last_a, 15'h3FFF);
    check("reload prg_bad", prg_bad - pbad, 0);
    check("reload chr_writes", chr_wr_cnt - cb, 1000);
    check("reload chr_last_a", chr_last_a, 14'd999);
    check("reload chr_bad", chr_bad - cbad, 0);
    check("reload busy", busy, 1);
    check("reload stalls", not_ready - nr, 0);

    // reset in the middle of CHR
    rst_n = 1'b0;
    tick();
    check_reset("rst_chr");
    cb = chr_wr_cnt;
    rst_n = 1'b1;
    tick();
    tick();
    check("post_rst chr_writes", chr_wr_cnt - cb, 0);
    check("post_rst ready", rx_ready, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
